// File: rtl/sat_bin_dispatch.sv
// sat_bin_dispatch: round-robin bin dispatcher for NUM_CORES sat_engine
// channels with a retry queue and global SAT/UNSAT aggregation.
module sat_bin_dispatch #(
   parameter int NUM_CORES    = 4,
   parameter int WIDTH_BIN_ID = 10,
   parameter int WIDTH_CORE   = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   input  logic [WIDTH_BIN_ID-1:0]           num_bins_i,
   output logic                              done_o,
   output logic                              global_sat_o,
   output logic                              global_unsat_o,
   output logic [NUM_CORES-1:0]              start_core_o,
   output logic [NUM_CORES*WIDTH_BIN_ID-1:0] cur_bin_num_o,
   input  logic [NUM_CORES-1:0]              done_core_i,
   input  logic [NUM_CORES-1:0]              local_sat_i,
   input  logic [NUM_CORES-1:0]              local_unsat_i
);

   localparam int CW = $clog2(NUM_CORES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef logic [WIDTH_BIN_ID-1:0] bin_t;
   typedef logic [CW-1:0]           cnt_t;
   typedef logic [WIDTH_CORE-1:0]   core_t;

   logic [1:0]           state_q, state_d;
   logic [NUM_CORES-1:0] busy_q, busy_d;
   logic [NUM_CORES-1:0] start_core_q, start_core_d;
   bin_t                 cur_bin_q [NUM_CORES];
   bin_t                 cur_bin_d [NUM_CORES];
   bin_t                 fifo_q [NUM_CORES];
   bin_t                 fifo_d [NUM_CORES];
   cnt_t                 fifo_cnt_q, fifo_cnt_d;
   core_t                rr_ptr_q, rr_ptr_d;
   bin_t                 sat_cnt_q, sat_cnt_d;
   bin_t                 next_bin_q, next_bin_d;
   bin_t                 num_bins_q, num_bins_d;
   logic                 done_q, done_d;
   logic                 gsat_q, gsat_d;
   logic                 gunsat_q, gunsat_d;

   logic                 accept;
   logic                 unsat_now;
   logic                 active;
   logic                 disp;
   logic                 fifo_pop;
   bin_t                 disp_bin;
   logic [NUM_CORES-1:0] fin;
   logic                 grant_vld;
   core_t                grant;
   core_t                widx;

   function automatic core_t wrap_idx(input core_t base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CORES) s = s - NUM_CORES;
      return core_t'(s);
   endfunction

   // First idle core at or after rr_ptr, wrapping around
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!grant_vld && !busy_q[wrap_idx(rr_ptr_q, i)]) begin
            grant     = wrap_idx(rr_ptr_q, i);
            grant_vld = 1'b1;
         end
      end
   end

   // Run control: start, verdict collection, dispatch, retry queue
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      start_core_d = '0;
      cur_bin_d    = cur_bin_q;
      fifo_d       = fifo_q;
      fifo_cnt_d   = fifo_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      sat_cnt_d    = sat_cnt_q;
      next_bin_d   = next_bin_q;
      num_bins_d   = num_bins_q;
      done_d       = done_q;
      gsat_d       = gsat_q;
      gunsat_d     = gunsat_q;
      unsat_now    = 1'b0;
      disp         = 1'b0;
      fifo_pop     = 1'b0;
      disp_bin     = '0;
      widx         = '0;

      accept = start_i && (state_q == S_IDLE || state_q == S_DONE);

      if (accept) begin
         num_bins_d = num_bins_i;
         sat_cnt_d  = '0;
         next_bin_d = '0;
         fifo_cnt_d = '0;
         done_d     = 1'b0;
         gsat_d     = 1'b0;
         gunsat_d   = 1'b0;
         if (num_bins_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            gsat_d  = 1'b1;
         end else begin
            state_d = S_RUN;
         end
      end

      // Finishing cores free up; verdicts only count while running
      fin    = done_core_i & busy_q;
      busy_d = busy_q & ~fin;
      if (state_q == S_RUN) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (fin[k]) begin
               if (local_unsat_i[k]) unsat_now = 1'b1;
               else if (local_sat_i[k]) sat_cnt_d = sat_cnt_d + bin_t'(1);
            end
         end
      end

      // A fresh start dispatches in its own cycle; UNSAT stops dispatch
      active = (state_q == S_RUN && !unsat_now) ||
               (accept && num_bins_i != '0);

      if (active && grant_vld) begin
         if (fifo_cnt_d != '0) begin
            disp     = 1'b1;
            fifo_pop = 1'b1;
            disp_bin = fifo_q[0];
         end else if (next_bin_d < num_bins_d) begin
            disp       = 1'b1;
            disp_bin   = next_bin_d;
            next_bin_d = next_bin_d + bin_t'(1);
         end
      end

      if (disp) begin
         start_core_d[grant] = 1'b1;
         busy_d[grant]       = 1'b1;
         cur_bin_d[grant]    = disp_bin;
         rr_ptr_d            = wrap_idx(grant, 1);
      end

      // Pop sees the old head; pushes follow in ascending core order
      if (fifo_pop) begin
         for (int i = 0; i < NUM_CORES - 1; i++) fifo_d[i] = fifo_q[i+1];
         fifo_cnt_d = fifo_cnt_d - cnt_t'(1);
      end
      if (state_q == S_RUN && !unsat_now) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (fin[k] && !local_sat_i[k] && !local_unsat_i[k]) begin
               widx         = fifo_cnt_d[WIDTH_CORE-1:0];
               fifo_d[widx] = cur_bin_q[k];
               fifo_cnt_d   = fifo_cnt_d + cnt_t'(1);
            end
         end
      end

      if (state_q == S_RUN) begin
         if (unsat_now) begin
            if (busy_d == '0) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               gunsat_d = 1'b1;
            end else begin
               state_d = S_FLUSH;
            end
         end else if (sat_cnt_d == num_bins_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            gsat_d  = 1'b1;
         end
      end else if (state_q == S_FLUSH) begin
         if (busy_d == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            gunsat_d = 1'b1;
         end
      end
   end

   // State, per-core bookkeeping and retry queue registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         busy_q       <= '0;
         start_core_q <= '0;
         cur_bin_q    <= '{default: '0};
         fifo_q       <= '{default: '0};
         fifo_cnt_q   <= '0;
         rr_ptr_q     <= '0;
         sat_cnt_q    <= '0;
         next_bin_q   <= '0;
         num_bins_q   <= '0;
         done_q       <= 1'b0;
         gsat_q       <= 1'b0;
         gunsat_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         start_core_q <= start_core_d;
         cur_bin_q    <= cur_bin_d;
         fifo_q       <= fifo_d;
         fifo_cnt_q   <= fifo_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         sat_cnt_q    <= sat_cnt_d;
         next_bin_q   <= next_bin_d;
         num_bins_q   <= num_bins_d;
         done_q       <= done_d;
         gsat_q       <= gsat_d;
         gunsat_q     <= gunsat_d;
      end
   end

   assign done_o         = done_q;
   assign global_sat_o   = gsat_q;
   assign global_unsat_o = gunsat_q;
   assign start_core_o   = start_core_q;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_bin
      assign cur_bin_num_o[g*WIDTH_BIN_ID +: WIDTH_BIN_ID] = cur_bin_q[g];
   end

endmodule

// File: tb/tb_sat_bin_dispatch.sv
// tb_sat_bin_dispatch: scoreboard bench for sat_bin_dispatch driven
// by a behavioural model of four sat_engine cores.
`timescale 1ns/1ps
module tb_sat_bin_dispatch;

   localparam int NC = 4;
   localparam int W  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_i = 1'b0;
   logic [W-1:0]  num_bins_i = '0;
   logic          done_o;
   logic          global_sat_o;
   logic          global_unsat_o;
   logic [NC-1:0] start_core_o;
   logic [NC*W-1:0] cur_bin_num_o;
   logic [NC-1:0] done_core_i = '0;
   logic [NC-1:0] local_sat_i = '0;
   logic [NC-1:0] local_unsat_i = '0;

   always #5 clk = ~clk;

   sat_bin_dispatch #(
      .NUM_CORES(NC), .WIDTH_BIN_ID(W), .WIDTH_CORE(2)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .num_bins_i(num_bins_i),
      .done_o(done_o), .global_sat_o(global_sat_o),
      .global_unsat_o(global_unsat_o), .start_core_o(start_core_o),
      .cur_bin_num_o(cur_bin_num_o), .done_core_i(done_core_i),
      .local_sat_i(local_sat_i), .local_unsat_i(local_unsat_i)
   );

   typedef struct { int cyc; int core; int bin; } disp_t;
   typedef struct { int cyc; logic sat; logic unsat; } res_t;

   disp_t exp_disp[$];
   res_t  exp_res[$];

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   s = 0;
   int   lat [NC];
   bit   act [NC];
   int   cbin [NC];
   int   due [NC];
   int   verd [1024];
   int   inj_cyc = -1;
   int   inj_core = 0;
   int   inj_start = -1;
   logic done_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_verd();
      for (int i = 0; i < 1024; i++) verd[i] = 0;
   endtask

   task automatic exp_d(input int rel, input int core, input int bin);
      disp_t e;
      e.cyc = s + rel; e.core = core; e.bin = bin;
      exp_disp.push_back(e);
   endtask

   task automatic exp_r(input int rel, input logic sat, input logic unsat);
      res_t r;
      r.cyc = s + rel; r.sat = sat; r.unsat = unsat;
      exp_res.push_back(r);
   endtask

   // One clock: drive core model after the edge, observe at negedge
   task automatic step();
      disp_t e;
      res_t  r;
      @(posedge clk); #1;
      cyc++;
      start_i = (cyc == inj_start);
      if (cyc == inj_start) num_bins_i = '0;
      done_core_i = '0; local_sat_i = '0; local_unsat_i = '0;
      for (int k = 0; k < NC; k++) begin
         if (act[k] && due[k] == cyc) begin
            done_core_i[k]   = 1'b1;
            local_sat_i[k]   = (verd[cbin[k]] == 0);
            local_unsat_i[k] = (verd[cbin[k]] == 1);
            if (verd[cbin[k]] == 2) verd[cbin[k]] = 0;
            act[k] = 1'b0;
         end
      end
      if (cyc == inj_cyc) begin
         done_core_i[inj_core] = 1'b1;
         local_sat_i[inj_core] = 1'b1;
      end
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         if (start_core_o[k]) begin
            if (exp_disp.size() == 0) begin
               check("unexpected_dispatch", start_core_o[k], 0);
            end else begin
               e = exp_disp.pop_front();
               check("disp_cycle", cyc, e.cyc);
               check("disp_core", k, e.core);
               check("disp_bin", cur_bin_num_o[k*W +: W], e.bin);
            end
            act[k]  = 1'b1;
            cbin[k] = int'(cur_bin_num_o[k*W +: W]);
            due[k]  = cyc + lat[k];
         end
      end
      if (done_o && !done_prev) begin
         if (exp_res.size() == 0) begin
            check("unexpected_done", done_o, 0);
         end else begin
            r = exp_res.pop_front();
            check("done_cycle", cyc, r.cyc);
            check("global_sat", global_sat_o, r.sat);
            check("global_unsat", global_unsat_o, r.unsat);
         end
      end
      done_prev = done_o;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((exp_disp.size() != 0 || exp_res.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("scoreboard_drained", exp_disp.size() + exp_res.size(), 0);
      repeat (4) step();
      inj_cyc = -1;
      inj_start = -1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < NC; k++) act[k] = 1'b0;
      exp_disp.delete();
      exp_res.delete();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_model();
      step(); step();
      rst = 1'b1;
      step();
   endtask

   task automatic go(input int nb);
      s = cyc;
      num_bins_i = W'(nb);
      start_i = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"}, done_o, 0);
      check({tag, "_gsat"}, global_sat_o, 0);
      check({tag, "_gunsat"}, global_unsat_o, 0);
      check({tag, "_start_core"}, start_core_o, 0);
      check({tag, "_cur_bin"}, cur_bin_num_o, 0);
   endtask

   initial begin
      clear_verd();
      lat = '{5, 5, 5, 5};
      do_reset();
      check_zero("reset");

      // Zero bins: immediate SAT, no dispatch
      go(0);
      exp_r(1, 1'b1, 1'b0);
      run(20);
      check("t1_done_held", done_o, 1);
      check("t1_gsat_held", global_sat_o, 1);

      // Three bins from DONE; spurious idle-core done and start in RUN
      go(3);
      exp_d(1, 0, 0); exp_d(2, 1, 1); exp_d(3, 2, 2);
      exp_r(9, 1'b1, 1'b0);
      inj_cyc = s + 2; inj_core = 3;
      inj_start = s + 5;
      run(40);

      // Retry of bin1 overtakes fresh bins
      do_reset();
      clear_verd();
      verd[1] = 2;
      lat = '{8, 5, 5, 5};
      go(6);
      exp_d(1, 0, 0); exp_d(2, 1, 1); exp_d(3, 2, 2); exp_d(4, 3, 3);
      exp_d(9, 1, 1); exp_d(10, 2, 4); exp_d(11, 3, 5);
      exp_r(17, 1'b1, 1'b0);
      run(60);

      // UNSAT flushes busy cores; start during FLUSH ignored
      do_reset();
      clear_verd();
      verd[2] = 1;
      lat = '{10, 12, 2, 4};
      go(8);
      exp_d(1, 0, 0); exp_d(2, 1, 1); exp_d(3, 2, 2); exp_d(4, 3, 3);
      exp_r(15, 1'b0, 1'b1);
      inj_start = s + 7;
      run(60);

      // All cores finish together; retry order, then SAT+UNSAT same cycle
      do_reset();
      clear_verd();
      verd[1] = 2; verd[3] = 2; verd[5] = 1;
      lat = '{8, 7, 6, 5};
      go(6);
      exp_d(1, 0, 0); exp_d(2, 1, 1); exp_d(3, 2, 2); exp_d(4, 3, 3);
      exp_d(11, 0, 1); exp_d(12, 1, 3); exp_d(13, 2, 4); exp_d(14, 3, 5);
      exp_r(20, 1'b0, 1'b1);
      run(60);

      // Asynchronous reset mid-run, then rr pointer restarts at core 0
      do_reset();
      clear_verd();
      lat = '{20, 20, 20, 20};
      go(10);
      exp_d(1, 0, 0); exp_d(2, 1, 1); exp_d(3, 2, 2);
      inj_start = s + 2;
      step(); step(); step();
      check("t6_disp_seen", exp_disp.size(), 0);
      rst = 1'b0;
      #1;
      check_zero("async_reset");
      clear_model();
      inj_start = -1;
      step(); step();
      check("t6_in_reset_start", start_core_o, 0);
      rst = 1'b1;
      step();
      lat = '{2, 2, 2, 2};
      go(1);
      exp_d(1, 0, 0);
      exp_r(4, 1'b1, 1'b0);
      run(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
